// File: rtl/bc_horner_if.sv
// Control-port bundle for bc_horner: request inputs from the sequencer's client
// and the load/select/address controls it drives into the polynomial datapath.
interface bc_horner_if #(
    parameter int DEGREE = 3
);
    localparam int CIDX_W = $clog2(DEGREE + 1);

    logic              i_start;
    logic              i_abort;
    logic              i_mode;
    logic              o_lx;
    logic              o_ls;
    logic              o_lh;
    logic              o_h;
    logic [1:0]        o_m0;
    logic [1:0]        o_m1;
    logic [1:0]        o_m2;
    logic [CIDX_W-1:0] o_coef_idx;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_abort, i_mode,
        input  o_lx, o_ls, o_lh, o_h, o_m0, o_m1, o_m2, o_coef_idx, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_mode,
        output o_lx, o_ls, o_lh, o_h, o_m0, o_m1, o_m2, o_coef_idx, o_busy, o_done
    );
endinterface

// File: rtl/bc_horner.sv
// Horner-evaluation sequencer: Moore FSM with step counter k, driving register
// loads, ALU op and mux selects for y = (..(a_N*x + a_N-1)*x + ..)*x + a_0.
module bc_horner #(
    parameter int DEGREE = 3
) (
    input logic        i_clk,
    input logic        i_rst_n,
    bc_horner_if.slave bus
);
    localparam int CIDX_W = $clog2(DEGREE + 1);
    localparam logic [CIDX_W-1:0] K_TOP   = CIDX_W'(DEGREE);
    localparam logic [CIDX_W-1:0] K_FIRST = CIDX_W'(DEGREE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADX,
        S_INIT,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              lx;
        logic              ls;
        logic              lh;
        logic              h;
        logic [1:0]        m0;
        logic [1:0]        m1;
        logic [1:0]        m2;
        logic [CIDX_W-1:0] cidx;
        logic              busy;
        logic              done;
    } ctl_t;

    state_t            r_state;
    state_t            w_nstate;
    logic [CIDX_W-1:0] r_k;
    logic [CIDX_W-1:0] w_nk;
    ctl_t              r_ctl;
    ctl_t              w_nctl;

    always_comb begin
        w_nstate = r_state;
        w_nk     = r_k;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_nstate = S_LOADX;
            S_LOADX: begin
                w_nk     = K_FIRST;
                w_nstate = S_INIT;
            end
            S_INIT:  w_nstate = S_MUL;
            S_MUL:   w_nstate = S_ADD;
            S_ADD: begin
                if (r_k == '0) begin
                    w_nstate = S_DONE;
                end else begin
                    w_nk     = r_k - 1'b1;
                    w_nstate = S_MUL;
                end
            end
            S_DONE:  w_nstate = bus.i_mode ? S_LOADX : S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
        if (bus.i_abort) w_nstate = S_IDLE;

        // Outputs are decoded from the next state/k so they can be registered
        // while still appearing in the same cycle as the state they belong to.
        w_nctl = '0;
        case (w_nstate)
            S_LOADX: begin
                w_nctl.lx   = 1'b1;
                w_nctl.m2   = 2'b00;
                w_nctl.cidx = K_TOP;
                w_nctl.busy = 1'b1;
            end
            S_INIT: begin
                w_nctl.ls   = 1'b1;
                w_nctl.m2   = 2'b01;
                w_nctl.cidx = K_TOP;
                w_nctl.busy = 1'b1;
            end
            S_MUL: begin
                w_nctl.lh   = 1'b1;
                w_nctl.h    = 1'b1;
                w_nctl.m0   = 2'b01;
                w_nctl.m1   = 2'b00;
                w_nctl.m2   = 2'b10;
                w_nctl.cidx = w_nk;
                w_nctl.busy = 1'b1;
            end
            S_ADD: begin
                w_nctl.ls   = 1'b1;
                w_nctl.h    = 1'b0;
                w_nctl.m0   = 2'b10;
                w_nctl.m1   = 2'b01;
                w_nctl.m2   = 2'b10;
                w_nctl.cidx = w_nk;
                w_nctl.busy = 1'b1;
            end
            S_DONE: begin
                w_nctl.done = 1'b1;
                w_nctl.busy = 1'b1;
            end
            default: w_nctl = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_nstate;
            r_k     <= w_nk;
            r_ctl   <= w_nctl;
        end
    end

    assign bus.o_lx       = r_ctl.lx;
    assign bus.o_ls       = r_ctl.ls;
    assign bus.o_lh       = r_ctl.lh;
    assign bus.o_h        = r_ctl.h;
    assign bus.o_m0       = r_ctl.m0;
    assign bus.o_m1       = r_ctl.m1;
    assign bus.o_m2       = r_ctl.m2;
    assign bus.o_coef_idx = r_ctl.cidx;
    assign bus.o_busy     = r_ctl.busy;
    assign bus.o_done     = r_ctl.done;
endmodule

// File: tb/tb_bc_horner.sv
// Directed bench for bc_horner: reset, single-shot with datapath stub,
// continuous mode, abort, ignored start, and a degree sweep.
module tb_bc_horner;
    logic clk;
    logic rst_n;
    logic sw_start;

    int n_tests;
    int n_fail;

    bc_horner_if #(.DEGREE(3)) if3 ();
    bc_horner_if #(.DEGREE(1)) if1 ();
    bc_horner_if #(.DEGREE(4)) if4 ();
    bc_horner_if #(.DEGREE(7)) if7 ();

    bc_horner #(.DEGREE(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
    bc_horner #(.DEGREE(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
    bc_horner #(.DEGREE(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
    bc_horner #(.DEGREE(7)) u_dut7 (.i_clk(clk), .i_rst_n(rst_n), .bus(if7));

    assign if1.i_start = sw_start;
    assign if1.i_abort = 1'b0;
    assign if1.i_mode  = 1'b0;
    assign if4.i_start = sw_start;
    assign if4.i_abort = 1'b0;
    assign if4.i_mode  = 1'b0;
    assign if7.i_start = sw_start;
    assign if7.i_abort = 1'b0;
    assign if7.i_mode  = 1'b0;

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Datapath stub: X, S, H registers driven purely by the controller outputs.
    logic [31:0] st_x, st_s, st_h;
    int          n_lx, n_ls;
    logic [31:0] coef [4];

    task automatic stub_step();
        logic [31:0] a, b, alu, wb;
        case (if3.o_m0)
            2'b00:   a = st_x;
            2'b01:   a = st_s;
            2'b10:   a = st_h;
            default: a = 0;
        endcase
        case (if3.o_m1)
            2'b00:   b = st_x;
            2'b01:   b = coef[if3.o_coef_idx];
            2'b10:   b = 1;
            default: b = st_s;
        endcase
        alu = if3.o_h ? a * b : a + b;
        case (if3.o_m2)
            2'b00:   wb = 2;
            2'b01:   wb = coef[if3.o_coef_idx];
            default: wb = alu;
        endcase
        if (if3.o_m2 != 2'b11) begin
            if (if3.o_lx) st_x = wb;
            if (if3.o_ls) st_s = wb;
            if (if3.o_lh) st_h = wb;
        end
        if (if3.o_lx) n_lx++;
        if (if3.o_ls) n_ls++;
    endtask

    function automatic logic [31:0] all_ctl3();
        return 32'({if3.o_lx, if3.o_ls, if3.o_lh, if3.o_h, if3.o_m0, if3.o_m1,
                    if3.o_m2, if3.o_coef_idx, if3.o_busy, if3.o_done});
    endfunction

    int ss_cidx [9];
    int d1_cidx [5];
    int sw_first [3];
    int sw_cnt [3];
    int sw_max [3];
    int n_done;
    int n_busy;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk = 1'b0;
        rst_n = 1'b1;
        sw_start = 1'b0;
        if3.i_start = 1'b0;
        if3.i_abort = 1'b0;
        if3.i_mode  = 1'b0;
        coef = '{1, 2, 3, 4};
        ss_cidx = '{3, 3, 2, 2, 1, 1, 0, 0, 0};
        d1_cidx = '{1, 1, 0, 0, 0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_ctl", all_ctl3(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_eq("idle_busy", 32'(if3.o_busy), 0);

        // Single-shot with datapath stub (x=2, a=[1,2,3,4])
        st_x = 0; st_s = 0; st_h = 0; n_lx = 0; n_ls = 0;
        if3.i_start = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if3.i_start = 1'b0;
            if (e <= 8) chk_eq("ss_cidx", 32'(if3.o_coef_idx), ss_cidx[e]);
            chk_eq("ss_busy", 32'(if3.o_busy), 32'(e <= 8));
            chk_eq("ss_done", 32'(if3.o_done), 32'(e == 8));
            stub_step();
        end
        chk_eq("ss_result", st_s, 49);
        chk_eq("ss_lx_count", n_lx, 1);
        chk_eq("ss_ls_count", n_ls, 4);

        // Continuous restart
        if3.i_mode  = 1'b1;
        if3.i_start = 1'b1;
        for (int e = 0; e <= 27; e++) begin
            tick();
            if3.i_start = 1'b0;
            chk_eq("ct_done", 32'(if3.o_done), 32'(e == 8 || e == 17 || e == 26));
            chk_eq("ct_lx", 32'(if3.o_lx), 32'(e % 9 == 0));
            chk_eq("ct_busy", 32'(if3.o_busy), 1);
        end
        if3.i_mode  = 1'b0;
        if3.i_abort = 1'b1;
        tick();
        if3.i_abort = 1'b0;
        chk_eq("ct_abort_busy", 32'(if3.o_busy), 0);

        // Abort in ADD with k=1
        if3.i_start = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if3.i_start = 1'b0;
        end
        chk_eq("ab_add_cidx", 32'(if3.o_coef_idx), 1);
        chk_eq("ab_add_ls", 32'(if3.o_ls), 1);
        if3.i_abort = 1'b1;
        tick();
        if3.i_abort = 1'b0;
        chk_eq("ab_busy", 32'(if3.o_busy), 0);
        chk_eq("ab_done", 32'(if3.o_done), 0);
        chk_eq("ab_cidx", 32'(if3.o_coef_idx), 0);
        n_done = 0;
        n_busy = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_done += int'(if3.o_done);
            n_busy += int'(if3.o_busy);
        end
        chk_eq("ab_no_done", n_done, 0);
        chk_eq("ab_stay_idle", n_busy, 0);

        // start and abort together in IDLE
        if3.i_start = 1'b1;
        if3.i_abort = 1'b1;
        tick();
        if3.i_start = 1'b0;
        if3.i_abort = 1'b0;
        chk_eq("sa_busy", 32'(if3.o_busy), 0);
        tick();
        chk_eq("sa_busy2", 32'(if3.o_busy), 0);

        // Asynchronous reset during the second MUL
        if3.i_start = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            if3.i_start = 1'b0;
        end
        chk_eq("rm_mul_lh", 32'(if3.o_lh), 1);
        chk_eq("rm_mul_cidx", 32'(if3.o_coef_idx), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("rm_ctl", all_ctl3(), 0);
        tick();
        rst_n = 1'b1;
        n_busy = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            n_busy += int'(if3.o_busy);
        end
        chk_eq("rm_stay_idle", n_busy, 0);

        // Degree sweep; DEGREE=1 also gets a second start while in MUL
        for (int j = 0; j < 3; j++) begin
            sw_first[j] = -1;
            sw_cnt[j]   = 0;
            sw_max[j]   = 0;
        end
        sw_start = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            tick();
            sw_start = (e == 2);
            if (e <= 4) chk_eq("d1_cidx", 32'(if1.o_coef_idx), d1_cidx[e]);
            chk_eq("d1_lx", 32'(if1.o_lx), 32'(e == 0));
            chk_eq("d1_busy", 32'(if1.o_busy), 32'(e <= 4));
            if (if1.o_done && sw_first[0] < 0) sw_first[0] = e;
            if (if4.o_done && sw_first[1] < 0) sw_first[1] = e;
            if (if7.o_done && sw_first[2] < 0) sw_first[2] = e;
            sw_cnt[0] += int'(if1.o_done);
            sw_cnt[1] += int'(if4.o_done);
            sw_cnt[2] += int'(if7.o_done);
            if (int'(if1.o_coef_idx) > sw_max[0]) sw_max[0] = int'(if1.o_coef_idx);
            if (int'(if4.o_coef_idx) > sw_max[1]) sw_max[1] = int'(if4.o_coef_idx);
            if (int'(if7.o_coef_idx) > sw_max[2]) sw_max[2] = int'(if7.o_coef_idx);
        end
        chk_eq("d1_done_edge", sw_first[0], 4);
        chk_eq("d4_done_edge", sw_first[1], 10);
        chk_eq("d7_done_edge", sw_first[2], 16);
        chk_eq("d1_done_count", sw_cnt[0], 1);
        chk_eq("d4_done_count", sw_cnt[1], 1);
        chk_eq("d7_done_count", sw_cnt[2], 1);
        chk_eq("d1_cidx_max", sw_max[0], 1);
        chk_eq("d4_cidx_max", sw_max[1], 4);
        chk_eq("d7_cidx_max", sw_max[2], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bc_horner.md
# bc_horner

Parametrised control block (BC) for the polynomial datapath. It sequences Horner evaluation y = (…(a_N·x + a_{N−1})·x + …)·x + a_0 for any degree N. It adds a start/busy/done handshake, an abort input and a continuous-restart mode. It drives the register loads (LX, LS, LH), the operation select (H), the three mux selects (M0, M1, M2) and the coefficient index into the coefficient ROM/register file.

## Interface
- DEGREE, 3, polynomial degree N; legal range ≥ 1
- CIDX_W, $clog2(DEGREE+1), width of coef_idx (localparam, derived)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request evaluation; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE from any state
- mode   in  1  0 = single-shot, 1 = continuous restart; sampled in DONE
- LX     out 1  load X register from input bus
- LS     out 1  load accumulator S
- LH     out 1  load product register H
- H      out 1  ALU op select: 1 = multiply, 0 = add
- M0     out 2  operand A select: 00 X, 01 S, 10 H, 11 zero
- M1     out 2  operand B select: 00 X, 01 coefficient, 10 constant 1, 11 S
- M2     out 2  write-back source: 00 input bus, 01 coefficient, 10 ALU result, 11 hold
- coef_idx out CIDX_W  coefficient address k
- busy   out 1  high in every state except IDLE
- done   out 1  one-cycle pulse in DONE

## Operation
- Moore FSM. All outputs decode from the state register and the step counter k only. There is no combinational path from any input to any output.
- States, with outputs; signals not listed are 0, and M0/M1/M2 are 00:
  - IDLE: coef_idx=0. If start=1 and abort=0, go to LOADX.
  - LOADX: LX=1, M2=00, coef_idx=DEGREE. k ← DEGREE−1. Go to INIT.
  - INIT: LS=1, M2=01, coef_idx=DEGREE (S ← a_N). Go to MUL.
  - MUL: LH=1, H=1, M0=01, M1=00, M2=10, coef_idx=k (H ← S·X). Go to ADD.
  - ADD: LS=1, H=0, M0=10, M1=01, M2=10, coef_idx=k (S ← H + a_k).
    - If k=0, go to DONE.
    - Otherwise k ← k−1 and go to MUL.
  - DONE: done=1, busy=1, coef_idx=0. If mode=1, go to LOADX; otherwise go to IDLE.
- k is CIDX_W bits wide, counts down only and never wraps. The k=0 test precedes the decrement.
- abort=1 in any state: next state is IDLE, with no done pulse. abort overrides start and mode in the same cycle.
- start in any state other than IDLE is ignored and is not queued.
- Asynchronous reset (reset=0): state=IDLE, k=0. All outputs are 0, including coef_idx, busy and done. This holds immediately, mid-sequence included. Operation resumes on the first rising edge after reset returns to 1.

## Timing
- The edge that samples start in IDLE is E0. State is LOADX after E0, INIT after E1, and the first MUL after E2.
- DONE holds after edge E(2·DEGREE+2). For DEGREE=3, that is E8.
- Single-shot: busy is high for 2·DEGREE+3 cycles. The earliest next start is sampled one cycle after DONE, in IDLE.
- Continuous (mode=1): back-to-back evaluations with period 2·DEGREE+3 cycles. busy stays high, and done pulses once per period.
- Load signals go high for exactly one cycle per state visit. LX is asserted exactly once per evaluation, and LS is asserted DEGREE+1 times.

## Test plan
- Reset mid-run: DEGREE=3, assert reset=0 while in the second MUL → busy=0, all outputs 0 and coef_idx=0 without waiting for a clock edge. After release, the FSM stays in IDLE until start.
- Single-shot, DEGREE=3: pulse start at E0 → coef_idx sequence 3,3,2,2,1,1,0,0,0 over states LOADX…DONE. done=1 only after E8, busy=1 after E0–E8 inclusive, then IDLE. Datapath stub with x=2 and a=[1,2,3,4] (a_0 first) yields S=49.
- Continuous, DEGREE=3, mode=1: done pulses at E8, E17 and E26, LX is high after E9, and busy never drops.
- Abort: assert abort for one cycle while in ADD with k=1 → IDLE on the next edge, no done pulse, busy=0. start and abort both high in IDLE → remains IDLE.
- Ignored start and minimum degree: DEGREE=1, pulse start again during MUL → sequence is LOADX, INIT, MUL, ADD, DONE with done after E4, and exactly one evaluation.
- Parameter sweep: DEGREE ∈ {1, 4, 7} → done after E(2·DEGREE+2), and the coef_idx maximum equals DEGREE without overflow.
